rvh_ptw_mem_bridge: RTL and testbench
=====================================

# rvh_ptw_mem_bridge

Bridges the MMU page-table-walker port to the data-side memory read channel. Sits directly downstream of the monolithic MMU. It accepts `ptw_walk_req_*` beats, registers them onto a memory read request channel, and tracks up to `MAX_OUTSTANDING` in-flight reads with a credit counter. It buffers returned PTEs in an in-order response FIFO and presents them on `ptw_walk_resp_*` with the original walk ID.

## Interface
- `PADDR_WIDTH`, 56, physical address width
- `PTW_ID_WIDTH`, 1, walk ID width
- `MAX_OUTSTANDING`, 2, max reads in flight plus buffered responses (power of 2, 1..4)
- `clk` in 1 — clock
- `rstn` in 1 — asynchronous active-low reset
- `ptw_walk_req_vld_i` in 1 — walk read request valid
- `ptw_walk_req_id_i` in PTW_ID_WIDTH — walk ID
- `ptw_walk_req_addr_i` in PADDR_WIDTH — PTE physical address
- `ptw_walk_req_rdy_o` out 1 — request accepted when vld&rdy
- `ptw_walk_resp_vld_o` out 1 — PTE response valid
- `ptw_walk_resp_id_o` out PTW_ID_WIDTH — ID of returned walk
- `ptw_walk_resp_pte_o` out 64 — PTE; forced to 0 on error
- `ptw_walk_resp_err_o` out 1 — access fault on this PTE read
- `ptw_walk_resp_rdy_i` in 1 — consumer ready
- `mem_req_vld_o` out 1 — memory read request valid
- `mem_req_addr_o` out PADDR_WIDTH — 8-byte aligned address
- `mem_req_rdy_i` in 1 — memory accepts request
- `mem_resp_vld_i` in 1 — read data valid; no backpressure, always accepted
- `mem_resp_data_i` in 64 — read data
- `mem_resp_err_i` in 1 — bus/access error

## Operation
- **Credit counter `cred_q`** (0..MAX_OUTSTANDING), reset MAX_OUTSTANDING.
  - Decrement on request acceptance; increment on response-FIFO pop.
  - Both in the same cycle: the count is unchanged.
- **Request stage** is one output register (vld, addr, id). The request side accepts when all three hold:
  - `ptw_walk_req_rdy_o = (cred_q != 0) & (~mem_req_vld_o | mem_req_rdy_i) & (~local_err_pending)`
- **Misaligned request** (`addr[2:0] != 0`) is never issued to memory.
  - It sets `local_err_pending` with its ID, consuming one credit.
  - The next cycle it enqueues an error response (pte=0, err=1), only if the FIFO has no in-flight memory response ahead of it.
  - Otherwise it waits in `local_err_pending` until in-flight count == 0.
  - `local_err_pending` clears on enqueue.
- **ID queue:** FIFO depth MAX_OUTSTANDING holds the IDs of issued memory reads.
  - Pushed when a request leaves to memory (`mem_req_vld_o & mem_req_rdy_i`).
  - Popped on `mem_resp_vld_i`.
- **Response FIFO:** depth MAX_OUTSTANDING, entries {id, pte, err}.
  - Pushed on `mem_resp_vld_i` with the ID-queue head; `pte = err ? 0 : data`.
  - Pushed on a local error enqueue.
  - Head drives `ptw_walk_resp_*`; popped on vld&rdy.
- **Protocol errors (assertions):**
  - `mem_resp_vld_i` with an empty ID queue.
  - FIFO push while full.
  - Credits guarantee neither occurs in legal operation.
- **Simultaneous memory response and local error enqueue:** not possible (ordering rule above). Assert it.

## Timing
- Reset values:
  - `mem_req_vld_o=0`, `mem_req_addr_o=0`
  - `ptw_walk_resp_vld_o=0`, id/pte/err = 0
  - `ptw_walk_req_rdy_o=1` (credits full, stage empty)
  - all FIFOs empty, `local_err_pending=0`
- Request latency: accept at cycle N gives `mem_req_vld_o` at N+1; held stable until `mem_req_rdy_i`.
- Back-to-back issue: one request per cycle when `mem_req_rdy_i=1` and credits allow.
- Response latency: `mem_resp_vld_i` at cycle M gives `ptw_walk_resp_vld_o` at M+1 (FIFO registered).
- Pop and push in the same cycle on a full FIFO is legal.
- Response outputs are held stable while `ptw_walk_resp_vld_o & ~ptw_walk_resp_rdy_i`.
- Reset mid-operation clears all state. In-flight memory responses after reset deassertion are the memory side's responsibility to suppress.

## Structure
- Add to the shared MMU package:
  - response entry struct {id, pte, err}
  - `PTE_ALIGN_BITS = 3`
- Sub-module `rvh_ptw_sync_fifo` (parametric width/depth, registered output, full/empty), instantiated twice: ID queue and response FIFO.
- Credit counter and request stage are in the top level.

## Test plan
1. **Single read:** addr=0x1000, id=1, mem_rdy=1, resp data=0x20000001 three cycles later → mem_req at N+1, addr=0x1000; ptw_resp vld at M+1, id=1, pte=0x20000001, err=0.
2. **Credit stall (MAX_OUTSTANDING=2):** three back-to-back requests, mem_rdy=1, no responses → third request sees rdy_o=0 after two accepts; rdy_o returns 1 the cycle after the first response pops.
3. **Backpressure:** mem_req_rdy_i=0 for 5 cycles → mem_req_vld_o and addr stable; rdy_o=0 after the stage fills.
4. **Memory error:** mem_resp_err_i=1 with data=0xFFFF → resp pte=0, err=1, correct id.
5. **Misaligned request:** addr=0x1004 → no mem_req; error response pte=0, err=1; it follows any prior in-flight response in order.
6. **Reset during traffic:** rstn low with 2 outstanding and resp stalled → all outputs at reset values; rdy_o=1 after release.

Source files
------------

// File: rtl/rvh_ptw_mem_bridge_pkg.sv
// Shared MMU types for the page-table-walker memory bridge:
// widths, response entry layout and the local-error tracker states.
package rvh_ptw_mem_bridge_pkg;

   localparam int PADDR_WIDTH             = 56;
   localparam int PTW_ID_WIDTH            = 1;
   localparam int PTE_WIDTH               = 64;
   localparam int PTE_ALIGN_BITS          = 3;
   localparam int DEFAULT_MAX_OUTSTANDING = 2;

   typedef logic [PADDR_WIDTH-1:0]  paddr_t;
   typedef logic [PTW_ID_WIDTH-1:0] ptw_id_t;
   typedef logic [PTE_WIDTH-1:0]    pte_t;

   typedef struct packed {
      ptw_id_t id;
      pte_t    pte;
      logic    err;
   } ptw_resp_entry_t;

   typedef enum logic {
      LERR_IDLE,
      LERR_PENDING
   } lerr_state_e;

   function automatic logic is_pte_aligned(input paddr_t addr);
      return addr[PTE_ALIGN_BITS-1:0] == '0;
   endfunction

   // A faulting read never exposes bus data to the walker.
   function automatic ptw_resp_entry_t make_resp(input ptw_id_t id, input pte_t data, input logic err);
      ptw_resp_entry_t entry;
      entry.id  = id;
      entry.pte = err ? '0 : data;
      entry.err = err;
      return entry;
   endfunction

endpackage

// File: rtl/rvh_ptw_mem_bridge_if.sv
// Walk request/response and memory read channel bundle between the MMU PTW
// and the data-side memory port.
interface rvh_ptw_mem_bridge_if;
   import rvh_ptw_mem_bridge_pkg::*;

   logic    ptw_walk_req_vld_i;
   ptw_id_t ptw_walk_req_id_i;
   paddr_t  ptw_walk_req_addr_i;
   logic    ptw_walk_req_rdy_o;

   logic    ptw_walk_resp_vld_o;
   ptw_id_t ptw_walk_resp_id_o;
   pte_t    ptw_walk_resp_pte_o;
   logic    ptw_walk_resp_err_o;
   logic    ptw_walk_resp_rdy_i;

   logic    mem_req_vld_o;
   paddr_t  mem_req_addr_o;
   logic    mem_req_rdy_i;

   logic    mem_resp_vld_i;
   pte_t    mem_resp_data_i;
   logic    mem_resp_err_i;

   modport slave (
      input  ptw_walk_req_vld_i,
      input  ptw_walk_req_id_i,
      input  ptw_walk_req_addr_i,
      output ptw_walk_req_rdy_o,
      output ptw_walk_resp_vld_o,
      output ptw_walk_resp_id_o,
      output ptw_walk_resp_pte_o,
      output ptw_walk_resp_err_o,
      input  ptw_walk_resp_rdy_i,
      output mem_req_vld_o,
      output mem_req_addr_o,
      input  mem_req_rdy_i,
      input  mem_resp_vld_i,
      input  mem_resp_data_i,
      input  mem_resp_err_i
   );

   modport master (
      output ptw_walk_req_vld_i,
      output ptw_walk_req_id_i,
      output ptw_walk_req_addr_i,
      input  ptw_walk_req_rdy_o,
      input  ptw_walk_resp_vld_o,
      input  ptw_walk_resp_id_o,
      input  ptw_walk_resp_pte_o,
      input  ptw_walk_resp_err_o,
      output ptw_walk_resp_rdy_i,
      input  mem_req_vld_o,
      input  mem_req_addr_o,
      output mem_req_rdy_i,
      output mem_resp_vld_i,
      output mem_resp_data_i,
      output mem_resp_err_i
   );

endinterface

// File: rtl/rvh_ptw_sync_fifo.sv
// Small synchronous FIFO with registered storage; the head entry reads as
// zero while empty so downstream outputs idle at a known value.
module rvh_ptw_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q;
   logic [PTR_W-1:0] rptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? '0 : mem_q[rptr_q];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= next_ptr(wptr_q);
         end
         if (do_pop) begin
            rptr_q <= next_ptr(rptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata;
      end
   end

   overflow_a: assert property (@(posedge clk) disable iff (!rstn) !(push && full && !pop));

endmodule

// File: rtl/rvh_ptw_mem_bridge.sv
// PTW-to-memory read bridge: registers walk requests onto the memory channel,
// bounds in-flight reads with credits and returns PTEs in walk order.
module rvh_ptw_mem_bridge
   import rvh_ptw_mem_bridge_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING
) (
   input logic                 clk,
   input logic                 rstn,
   rvh_ptw_mem_bridge_if.slave bus
);

   localparam int CRED_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int RESP_W = $bits(ptw_resp_entry_t);

   logic [CRED_W-1:0] cred_q;
   logic              req_rdy;
   logic              req_fire;
   logic              req_aligned;
   logic              issue_fire;
   logic              resp_pop;
   logic              local_enq;
   logic              local_err_pending;

   lerr_state_e       lerr_state_q;
   lerr_state_e       lerr_state_d;
   ptw_id_t           lerr_id_q;

   logic              mem_req_vld_q;
   paddr_t            mem_req_addr_q;
   ptw_id_t           mem_req_id_q;

   ptw_id_t           idq_head;
   logic              idq_full;
   logic              idq_empty;

   ptw_resp_entry_t   rsp_wdata;
   ptw_resp_entry_t   rsp_rdata;
   logic              rsp_push;
   logic              rsp_full;
   logic              rsp_empty;

   assign local_err_pending = (lerr_state_q == LERR_PENDING);
   assign req_rdy     = (cred_q != '0) & (~mem_req_vld_q | bus.mem_req_rdy_i) & ~local_err_pending;
   assign req_fire    = bus.ptw_walk_req_vld_i & req_rdy;
   assign req_aligned = is_pte_aligned(bus.ptw_walk_req_addr_i);
   assign issue_fire  = mem_req_vld_q & bus.mem_req_rdy_i;
   assign resp_pop    = ~rsp_empty & bus.ptw_walk_resp_rdy_i;

   // One credit covers a walk from acceptance until its response is consumed.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cred_q <= CRED_W'(MAX_OUTSTANDING);
      end else if (req_fire && !resp_pop) begin
         cred_q <= cred_q - 1'b1;
      end else if (!req_fire && resp_pop) begin
         cred_q <= cred_q + 1'b1;
      end
   end

   // Request stage: misaligned walks never reach memory.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_req_vld_q  <= 1'b0;
         mem_req_addr_q <= '0;
         mem_req_id_q   <= '0;
      end else if (req_fire && req_aligned) begin
         mem_req_vld_q  <= 1'b1;
         mem_req_addr_q <= bus.ptw_walk_req_addr_i;
         mem_req_id_q   <= bus.ptw_walk_req_id_i;
      end else if (bus.mem_req_rdy_i) begin
         mem_req_vld_q  <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lerr_state_q <= LERR_IDLE;
      end else begin
         lerr_state_q <= lerr_state_d;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lerr_id_q <= '0;
      end else if (req_fire && !req_aligned) begin
         lerr_id_q <= bus.ptw_walk_req_id_i;
      end
   end

   // A local error may only be queued once every earlier memory read has
   // returned, which keeps responses in walk order.
   always_comb begin
      lerr_state_d = lerr_state_q;
      local_enq    = 1'b0;
      case (lerr_state_q)
         LERR_IDLE: begin
            if (req_fire && !req_aligned) begin
               lerr_state_d = LERR_PENDING;
            end
         end
         LERR_PENDING: begin
            if (!mem_req_vld_q && idq_empty) begin
               local_enq    = 1'b1;
               lerr_state_d = LERR_IDLE;
            end
         end
         default: lerr_state_d = LERR_IDLE;
      endcase
   end

   rvh_ptw_sync_fifo #(
      .WIDTH (PTW_ID_WIDTH),
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_queue (
      .clk   (clk),
      .rstn  (rstn),
      .push  (issue_fire),
      .wdata (mem_req_id_q),
      .pop   (bus.mem_resp_vld_i),
      .rdata (idq_head),
      .full  (idq_full),
      .empty (idq_empty)
   );

   always_comb begin
      rsp_push  = bus.mem_resp_vld_i | local_enq;
      rsp_wdata = make_resp(lerr_id_q, '0, 1'b1);
      if (bus.mem_resp_vld_i) begin
         rsp_wdata = make_resp(idq_head, bus.mem_resp_data_i, bus.mem_resp_err_i);
      end
   end

   rvh_ptw_sync_fifo #(
      .WIDTH (RESP_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_resp_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (rsp_push),
      .wdata (rsp_wdata),
      .pop   (resp_pop),
      .rdata (rsp_rdata),
      .full  (rsp_full),
      .empty (rsp_empty)
   );

   assign bus.ptw_walk_req_rdy_o  = req_rdy;
   assign bus.mem_req_vld_o       = mem_req_vld_q;
   assign bus.mem_req_addr_o      = mem_req_addr_q;
   assign bus.ptw_walk_resp_vld_o = ~rsp_empty;
   assign bus.ptw_walk_resp_id_o  = rsp_rdata.id;
   assign bus.ptw_walk_resp_pte_o = rsp_rdata.pte;
   assign bus.ptw_walk_resp_err_o = rsp_rdata.err;

   resp_without_read_a: assert property (@(posedge clk) disable iff (!rstn)
      bus.mem_resp_vld_i |-> !idq_empty);
   id_queue_overflow_a: assert property (@(posedge clk) disable iff (!rstn)
      (issue_fire && idq_full) |-> bus.mem_resp_vld_i);
   resp_fifo_overflow_a: assert property (@(posedge clk) disable iff (!rstn)
      (rsp_push && rsp_full) |-> resp_pop);
   resp_vs_local_err_a: assert property (@(posedge clk) disable iff (!rstn)
      !(bus.mem_resp_vld_i && local_enq));

endmodule

// File: tb/tb_rvh_ptw_mem_bridge.sv
// Directed and randomized checks of the PTW memory bridge against an in-order
// transaction model of walks, memory reads and returned PTEs.
module tb_rvh_ptw_mem_bridge;
   import rvh_ptw_mem_bridge_pkg::*;

   localparam int MAX_OUT = DEFAULT_MAX_OUTSTANDING;

   typedef struct {
      ptw_id_t id;
      bit      mis;
   } walk_t;

   logic clk = 1'b0;
   logic rstn;
   int   n_cmp  = 0;
   int   n_fail = 0;

   walk_t       exp_q[$];
   paddr_t      mem_exp_q[$];
   logic [64:0] data_q[$];
   int          issued;
   int          returned;
   logic        prev_mreq_stall;
   paddr_t      prev_mreq_addr;
   logic        prev_resp_stall;
   logic [65:0] prev_resp;

   rvh_ptw_mem_bridge_if bif();

   rvh_ptw_mem_bridge #(
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bif)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_cmp++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic req_vld, input logic [63:0] id, input logic [63:0] addr,
                                 input logic mem_rdy, input logic resp_rdy);
      bif.ptw_walk_req_vld_i  = req_vld;
      bif.ptw_walk_req_id_i   = PTW_ID_WIDTH'(id);
      bif.ptw_walk_req_addr_i = PADDR_WIDTH'(addr);
      bif.mem_req_rdy_i       = mem_rdy;
      bif.ptw_walk_resp_rdy_i = resp_rdy;
      settle();
   endtask

   task automatic mem_pulse(input logic [63:0] data, input logic err);
      bif.mem_resp_vld_i  = 1'b1;
      bif.mem_resp_data_i = data;
      bif.mem_resp_err_i  = err;
      tick();
      bif.mem_resp_vld_i  = 1'b0;
      bif.mem_resp_err_i  = 1'b0;
   endtask

   task automatic pop_resp(input string tag, input logic [63:0] id, input logic [63:0] pte, input logic [63:0] err);
      int waited = 0;
      while (bif.ptw_walk_resp_vld_o !== 1'b1 && waited < 16) begin
         tick();
         waited++;
      end
      check_output({tag, "_vld"}, 64'(bif.ptw_walk_resp_vld_o), 1);
      check_output({tag, "_id"},  64'(bif.ptw_walk_resp_id_o), id);
      check_output({tag, "_pte"}, bif.ptw_walk_resp_pte_o, pte);
      check_output({tag, "_err"}, 64'(bif.ptw_walk_resp_err_o), err);
      bif.ptw_walk_resp_rdy_i = 1'b1;
      tick();
      bif.ptw_walk_resp_rdy_i = 1'b0;
      settle();
   endtask

   task automatic check_reset_values(input string tag);
      check_output({tag, "_mreq_vld"}, 64'(bif.mem_req_vld_o), 0);
      check_output({tag, "_mreq_addr"}, 64'(bif.mem_req_addr_o), 0);
      check_output({tag, "_resp_vld"}, 64'(bif.ptw_walk_resp_vld_o), 0);
      check_output({tag, "_resp_id"}, 64'(bif.ptw_walk_resp_id_o), 0);
      check_output({tag, "_resp_pte"}, bif.ptw_walk_resp_pte_o, 0);
      check_output({tag, "_resp_err"}, 64'(bif.ptw_walk_resp_err_o), 0);
      check_output({tag, "_req_rdy"}, 64'(bif.ptw_walk_req_rdy_o), 1);
   endtask

   // One clock of random traffic; handshakes seen before the edge update the model.
   task automatic random_cycle(input bit allow);
      walk_t       w;
      walk_t       e;
      logic [64:0] d;
      paddr_t      a;
      logic [63:0] exp_pte;
      logic [63:0] exp_err;

      a = PADDR_WIDTH'({$urandom, $urandom});
      a[2:0] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      bif.ptw_walk_req_vld_i  = allow && ($urandom_range(0, 2) != 0);
      bif.ptw_walk_req_id_i   = PTW_ID_WIDTH'($urandom);
      bif.ptw_walk_req_addr_i = a;
      bif.mem_req_rdy_i       = allow ? ($urandom_range(0, 3) != 0) : 1'b1;
      bif.ptw_walk_resp_rdy_i = allow ? ($urandom_range(0, 1) != 0) : 1'b1;
      bif.mem_resp_vld_i      = (issued > returned) && ($urandom_range(0, 1) != 0);
      bif.mem_resp_data_i     = {$urandom, $urandom};
      bif.mem_resp_err_i      = ($urandom_range(0, 7) == 0);
      settle();

      if (prev_mreq_stall) begin
         check_output("rnd_mreq_hold_vld", 64'(bif.mem_req_vld_o), 1);
         check_output("rnd_mreq_hold_addr", 64'(bif.mem_req_addr_o), 64'(prev_mreq_addr));
      end
      if (prev_resp_stall) begin
         check_output("rnd_resp_hold_vld", 64'(bif.ptw_walk_resp_vld_o), 1);
         check_output("rnd_resp_hold_pte", bif.ptw_walk_resp_pte_o, prev_resp[64:1]);
         check_output("rnd_resp_hold_iderr", 64'({bif.ptw_walk_resp_id_o, bif.ptw_walk_resp_err_o}),
                      64'({prev_resp[65], prev_resp[0]}));
      end
      if (exp_q.size() == MAX_OUT) begin
         check_output("rnd_credit_full", 64'(bif.ptw_walk_req_rdy_o), 0);
      end

      if (bif.ptw_walk_resp_vld_o && bif.ptw_walk_resp_rdy_i) begin
         check_output("rnd_resp_expected", 64'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            exp_pte = 0;
            exp_err = 1;
            if (!e.mis) begin
               check_output("rnd_data_avail", 64'(data_q.size() != 0), 1);
               if (data_q.size() != 0) begin
                  d = data_q.pop_front();
                  exp_err = 64'(d[64]);
                  exp_pte = d[64] ? 64'd0 : d[63:0];
               end
            end
            check_output("rnd_resp_id", 64'(bif.ptw_walk_resp_id_o), 64'(e.id));
            check_output("rnd_resp_pte", bif.ptw_walk_resp_pte_o, exp_pte);
            check_output("rnd_resp_err", 64'(bif.ptw_walk_resp_err_o), exp_err);
         end
      end
      if (bif.mem_req_vld_o && bif.mem_req_rdy_i) begin
         check_output("rnd_issue_expected", 64'(mem_exp_q.size() != 0), 1);
         if (mem_exp_q.size() != 0) begin
            check_output("rnd_issue_addr", 64'(bif.mem_req_addr_o), 64'(mem_exp_q.pop_front()));
         end
         issued++;
      end
      if (bif.mem_resp_vld_i) begin
         data_q.push_back({bif.mem_resp_err_i, bif.mem_resp_data_i});
         returned++;
      end
      if (bif.ptw_walk_req_vld_i && bif.ptw_walk_req_rdy_o) begin
         w.id  = bif.ptw_walk_req_id_i;
         w.mis = (a[2:0] != 3'b000);
         exp_q.push_back(w);
         if (!w.mis) begin
            mem_exp_q.push_back(a);
         end
      end

      prev_mreq_stall = bif.mem_req_vld_o && !bif.mem_req_rdy_i;
      prev_mreq_addr  = bif.mem_req_addr_o;
      prev_resp_stall = bif.ptw_walk_resp_vld_o && !bif.ptw_walk_resp_rdy_i;
      prev_resp       = {bif.ptw_walk_resp_id_o, bif.ptw_walk_resp_pte_o, bif.ptw_walk_resp_err_o};
      tick();
   endtask

   initial begin
      rstn = 1'b0;
      bif.ptw_walk_req_vld_i  = 1'b0;
      bif.ptw_walk_req_id_i   = '0;
      bif.ptw_walk_req_addr_i = '0;
      bif.ptw_walk_resp_rdy_i = 1'b0;
      bif.mem_req_rdy_i       = 1'b0;
      bif.mem_resp_vld_i      = 1'b0;
      bif.mem_resp_data_i     = '0;
      bif.mem_resp_err_i      = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      #2 rstn = 1'b1;
      tick();

      $display("[TB] single read");
      apply_stimulus(1'b1, 1, 'h1000, 1'b1, 1'b0);
      check_output("t1_rdy", 64'(bif.ptw_walk_req_rdy_o), 1);
      tick();
      apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
      check_output("t1_mreq_vld", 64'(bif.mem_req_vld_o), 1);
      check_output("t1_mreq_addr", 64'(bif.mem_req_addr_o), 'h1000);
      tick();
      check_output("t1_mreq_done", 64'(bif.mem_req_vld_o), 0);
      tick();
      bif.mem_resp_vld_i  = 1'b1;
      bif.mem_resp_data_i = 64'h2000_0001;
      settle();
      check_output("t1_resp_not_yet", 64'(bif.ptw_walk_resp_vld_o), 0);
      tick();
      bif.mem_resp_vld_i = 1'b0;
      check_output("t1_resp_vld", 64'(bif.ptw_walk_resp_vld_o), 1);
      pop_resp("t1", 1, 64'h2000_0001, 0);
      check_output("t1_resp_drained", 64'(bif.ptw_walk_resp_vld_o), 0);

      $display("[TB] credit stall");
      apply_stimulus(1'b1, 0, 'h2000, 1'b1, 1'b0);
      check_output("t2_rdy_a", 64'(bif.ptw_walk_req_rdy_o), 1);
      tick();
      apply_stimulus(1'b1, 1, 'h2008, 1'b1, 1'b0);
      check_output("t2_rdy_b", 64'(bif.ptw_walk_req_rdy_o), 1);
      tick();
      apply_stimulus(1'b1, 0, 'h2010, 1'b1, 1'b0);
      check_output("t2_rdy_c", 64'(bif.ptw_walk_req_rdy_o), 0);
      tick();
      check_output("t2_rdy_hold", 64'(bif.ptw_walk_req_rdy_o), 0);
      mem_pulse(64'h11, 1'b0);
      check_output("t2_rdy_before_pop", 64'(bif.ptw_walk_req_rdy_o), 0);
      check_output("t2_first_pte", bif.ptw_walk_resp_pte_o, 64'h11);
      bif.ptw_walk_resp_rdy_i = 1'b1;
      tick();
      bif.ptw_walk_resp_rdy_i = 1'b0;
      settle();
      check_output("t2_rdy_after_pop", 64'(bif.ptw_walk_req_rdy_o), 1);
      tick();
      apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
      check_output("t2_third_addr", 64'(bif.mem_req_addr_o), 'h2010);
      tick();
      mem_pulse(64'h22, 1'b0);
      mem_pulse(64'h33, 1'b0);
      pop_resp("t2_second", 1, 64'h22, 0);
      pop_resp("t2_third", 0, 64'h33, 0);

      $display("[TB] backpressure and memory error");
      apply_stimulus(1'b1, 0, 'h3000, 1'b0, 1'b0);
      tick();
      apply_stimulus(1'b1, 1, 'h3008, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check_output("t3_hold_vld", 64'(bif.mem_req_vld_o), 1);
         check_output("t3_hold_addr", 64'(bif.mem_req_addr_o), 'h3000);
         check_output("t3_rdy_low", 64'(bif.ptw_walk_req_rdy_o), 0);
         tick();
      end
      apply_stimulus(1'b1, 1, 'h3008, 1'b1, 1'b0);
      check_output("t3_release", 64'(bif.ptw_walk_req_rdy_o), 1);
      tick();
      apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
      check_output("t3_next_addr", 64'(bif.mem_req_addr_o), 'h3008);
      tick();
      mem_pulse(64'hAAAA, 1'b0);
      mem_pulse(64'hFFFF, 1'b1);
      pop_resp("t4_ok", 0, 64'hAAAA, 0);
      pop_resp("t4_err", 1, 0, 1);

      $display("[TB] misaligned walk");
      apply_stimulus(1'b1, 1, 'h4000, 1'b1, 1'b0);
      tick();
      apply_stimulus(1'b1, 0, 'h4004, 1'b1, 1'b0);
      check_output("t5_rdy", 64'(bif.ptw_walk_req_rdy_o), 1);
      tick();
      apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
      check_output("t5_no_issue", 64'(bif.mem_req_vld_o), 0);
      check_output("t5_pending_rdy", 64'(bif.ptw_walk_req_rdy_o), 0);
      tick();
      tick();
      check_output("t5_waits", 64'(bif.ptw_walk_resp_vld_o), 0);
      check_output("t5_still_no_issue", 64'(bif.mem_req_vld_o), 0);
      mem_pulse(64'h1234, 1'b0);
      pop_resp("t5_first", 1, 64'h1234, 0);
      pop_resp("t5_err", 0, 0, 1);
      apply_stimulus(1'b1, 1, 'h5003, 1'b1, 1'b0);
      tick();
      apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
      check_output("t5_solo_no_issue", 64'(bif.mem_req_vld_o), 0);
      pop_resp("t5_solo", 1, 0, 1);

      $display("[TB] reset during traffic");
      apply_stimulus(1'b1, 0, 'h6000, 1'b1, 1'b0);
      tick();
      apply_stimulus(1'b1, 1, 'h6008, 1'b1, 1'b0);
      tick();
      apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
      tick();
      mem_pulse(64'h66, 1'b0);
      mem_pulse(64'h77, 1'b0);
      check_output("t6_pre_vld", 64'(bif.ptw_walk_resp_vld_o), 1);
      check_output("t6_pre_rdy", 64'(bif.ptw_walk_req_rdy_o), 0);
      #1 rstn = 1'b0;
      #1;
      check_reset_values("t6_in_reset");
      @(negedge clk);
      rstn = 1'b1;
      tick();
      check_output("t6_rdy_after", 64'(bif.ptw_walk_req_rdy_o), 1);

      $display("[TB] random traffic");
      issued          = 0;
      returned        = 0;
      prev_mreq_stall = 1'b0;
      prev_mreq_addr  = '0;
      prev_resp_stall = 1'b0;
      prev_resp       = '0;
      for (int cyc = 0; cyc < 700; cyc++) begin
         random_cycle(cyc < 550);
      end
      apply_stimulus(1'b0, 0, 0, 1'b1, 1'b0);
      check_output("drain_walks", 64'(exp_q.size()), 0);
      check_output("drain_issues", 64'(mem_exp_q.size()), 0);
      check_output("drain_data", 64'(data_q.size()), 0);
      check_output("drain_resp_vld", 64'(bif.ptw_walk_resp_vld_o), 0);
      check_output("drain_rdy", 64'(bif.ptw_walk_req_rdy_o), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
